// File: rtl/clk_div_pkg.sv
// Shared types and constants for the clock-divider configuration sequencer.
// Prescale map constants are used only when CLK_DIV_PRESCALE_MAP_EN is defined.
package clk_div_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        DRAIN,
        LOAD,
        SETTLE
    } state_e;

    localparam int RESET_RATIO = 1;

    localparam int PRESCALE_CODE_32 = 32;
    localparam int PRESCALE_CODE_16 = 16;
    localparam int PRESCALE_CODE_8  = 8;
    localparam int PRESCALE_CODE_4  = 4;

    localparam int MAP_RATIO_32 = 1;
    localparam int MAP_RATIO_16 = 2;
    localparam int MAP_RATIO_8  = 4;
    localparam int MAP_RATIO_4  = 8;

endpackage

// File: rtl/clk_div_cfg_decode.sv
// Combinational legality check and ratio decode for a configuration request.
// Raw ratio by default; UART prescale-code mapping when CLK_DIV_PRESCALE_MAP_EN is defined.
module clk_div_cfg_decode
    import clk_div_pkg::*;
#(
    parameter int MAX_RATIO = 10,
    parameter int RATIO_BIT = $clog2(MAX_RATIO) + 1,
    parameter int CFG_BIT   = 6
) (
    input  logic [CFG_BIT-1:0]   i_cfg_data,
    output logic                 o_legal,
    output logic [RATIO_BIT-1:0] o_ratio
);

`ifdef CLK_DIV_PRESCALE_MAP_EN
    int mapped;

    // Unknown codes map to 0, which doubles as the illegal marker.
    always_comb begin
        mapped = 0;
        case (i_cfg_data)
            CFG_BIT'(PRESCALE_CODE_32): mapped = MAP_RATIO_32;
            CFG_BIT'(PRESCALE_CODE_16): mapped = MAP_RATIO_16;
            CFG_BIT'(PRESCALE_CODE_8):  mapped = MAP_RATIO_8;
            CFG_BIT'(PRESCALE_CODE_4):  mapped = MAP_RATIO_4;
            default:                    mapped = 0;
        endcase
        o_legal = (mapped != 0) && (mapped <= MAX_RATIO);
        o_ratio = RATIO_BIT'(mapped);
    end
`else
    always_comb begin
        o_legal = (i_cfg_data != '0) && (i_cfg_data <= CFG_BIT'(MAX_RATIO));
        o_ratio = RATIO_BIT'(i_cfg_data);
    end
`endif

endmodule

// File: rtl/clk_div_cfg.sv
// Configuration sequencer ahead of the clock divider: drains, reloads and settles on ratio change.
// Request format selected by CLK_DIV_PRESCALE_MAP_EN (prescale codes) or raw ratios when undefined.
module clk_div_cfg
    import clk_div_pkg::*;
#(
    parameter int MAX_RATIO     = 10,
    parameter int RATIO_BIT     = $clog2(MAX_RATIO) + 1,
    parameter int CFG_BIT       = 6,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                 i_ref_clk,
    input  logic                 i_rst,
    input  logic [CFG_BIT-1:0]   i_cfg_data,
    input  logic                 i_cfg_valid,
    input  logic                 i_run,
    output logic [RATIO_BIT-1:0] o_div_ratio,
    output logic                 o_clk_en,
    output logic                 o_busy,
    output logic                 o_cfg_err
);

    localparam int CNT_BIT = (RATIO_BIT + 1 > 4) ? RATIO_BIT + 1 : 4;
    localparam logic [CNT_BIT-1:0] SETTLE_CNT = CNT_BIT'(SETTLE_CYCLES);

    state_e               state_q, state_d;
    logic [CNT_BIT-1:0]   cnt_q, cnt_d;
    logic [RATIO_BIT-1:0] ratio_q, ratio_d;
    logic [RATIO_BIT-1:0] pend_q, pend_d;
    logic                 pend_vld_q, pend_vld_d;
    logic                 clk_en_q, clk_en_d;
    logic                 busy_q, busy_d;
    logic                 cfg_err_q, cfg_err_d;

    logic                 dec_legal;
    logic [RATIO_BIT-1:0] dec_ratio;
    logic                 accept;
    logic                 req_ok;
    logic                 req_bad;

    clk_div_cfg_decode #(
        .MAX_RATIO (MAX_RATIO),
        .RATIO_BIT (RATIO_BIT),
        .CFG_BIT   (CFG_BIT)
    ) u_decode (
        .i_cfg_data (i_cfg_data),
        .o_legal    (dec_legal),
        .o_ratio    (dec_ratio)
    );

    assign accept  = i_cfg_valid && ((state_q == IDLE) || (state_q == RUN));
    assign req_ok  = accept && dec_legal;
    assign req_bad = accept && !dec_legal;

    // Each counted phase lasts exactly its loaded count: exit on the cycle the counter reads 1.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ratio_d    = ratio_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        cfg_err_d  = cfg_err_q;

        if (req_ok) begin
            cfg_err_d  = 1'b0;
            pend_d     = dec_ratio;
            pend_vld_d = 1'b1;
        end else if (req_bad) begin
            cfg_err_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (req_ok) begin
                    state_d = LOAD;
                end else if (i_run) begin
                    state_d = SETTLE;
                    cnt_d   = SETTLE_CNT;
                end
            end
            RUN: begin
                if (req_ok || !i_run) begin
                    state_d = DRAIN;
                    cnt_d   = CNT_BIT'({ratio_q, 1'b0});
                end
            end
            DRAIN: begin
                if (cnt_q <= CNT_BIT'(1)) begin
                    cnt_d   = '0;
                    state_d = pend_vld_q ? LOAD : IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_BIT'(1);
                end
            end
            LOAD: begin
                ratio_d    = pend_q;
                pend_vld_d = 1'b0;
                cnt_d      = SETTLE_CNT;
                state_d    = SETTLE;
            end
            SETTLE: begin
                if (cnt_q <= CNT_BIT'(1)) begin
                    cnt_d   = '0;
                    state_d = i_run ? RUN : IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_BIT'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        clk_en_d = (state_d == RUN);
        busy_d   = (state_d == DRAIN) || (state_d == LOAD) || (state_d == SETTLE);
    end

    always_ff @(posedge i_ref_clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            ratio_q    <= RATIO_BIT'(RESET_RATIO);
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            clk_en_q   <= 1'b0;
            busy_q     <= 1'b0;
            cfg_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ratio_q    <= ratio_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            clk_en_q   <= clk_en_d;
            busy_q     <= busy_d;
            cfg_err_q  <= cfg_err_d;
        end
    end

    assign o_div_ratio = ratio_q;
    assign o_clk_en    = clk_en_q;
    assign o_busy      = busy_q;
    assign o_cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_clk_div_cfg.sv
// Self-checking bench for clk_div_cfg: timeline-based reference model plus directed literal checks.
// Directed request codes follow CLK_DIV_PRESCALE_MAP_EN when it is defined.
module tb_clk_div_cfg;

    localparam int MAX_RATIO     = 10;
    localparam int SETTLE_CYCLES = 4;

`ifdef CLK_DIV_PRESCALE_MAP_EN
    localparam logic [5:0] CODE_A = 6'd8;
    localparam int         RAT_A  = 4;
    localparam logic [5:0] BAD1   = 6'd12;
    localparam logic [5:0] BAD2   = 6'd5;
    localparam logic [5:0] CODE_B = 6'd16;
    localparam int         RAT_B  = 2;
    localparam logic [5:0] CODE_C = 6'd4;
    localparam int         RAT_C  = 8;
    localparam logic [5:0] CODE_D = 6'd32;
`else
    localparam logic [5:0] CODE_A = 6'd4;
    localparam int         RAT_A  = 4;
    localparam logic [5:0] BAD1   = 6'd0;
    localparam logic [5:0] BAD2   = 6'd11;
    localparam logic [5:0] CODE_B = 6'd3;
    localparam int         RAT_B  = 3;
    localparam logic [5:0] CODE_C = 6'd5;
    localparam int         RAT_C  = 5;
    localparam logic [5:0] CODE_D = 6'd6;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] cfg_data = '0;
    logic       cfg_valid = 1'b0;
    logic       run = 1'b0;
    logic [4:0] div_ratio;
    logic       clk_en;
    logic       busy;
    logic       cfg_err;

    int checks = 0;
    int fails  = 0;

    clk_div_cfg dut (
        .i_ref_clk   (clk),
        .i_rst       (rst),
        .i_cfg_data  (cfg_data),
        .i_cfg_valid (cfg_valid),
        .i_run       (run),
        .o_div_ratio (div_ratio),
        .o_clk_en    (clk_en),
        .o_busy      (busy),
        .o_cfg_err   (cfg_err)
    );

    always #5 clk = ~clk;

    // Reference model: a reconfiguration is a timeline of absolute edge numbers, not a state machine.
    bit m_armed = 0;
    int cyc = 0;
    bit m_en, m_busy, m_err, m_has_pend, m_settle_end;
    int m_ratio, m_pend, m_apply, m_decide;

    function automatic void model_decode(input int code, output bit ok, output int r);
`ifdef CLK_DIV_PRESCALE_MAP_EN
        case (code)
            32:      r = 1;
            16:      r = 2;
            8:       r = 4;
            4:       r = 8;
            default: r = 0;
        endcase
        ok = (r != 0) && (r <= MAX_RATIO);
`else
        r  = code;
        ok = (code >= 1) && (code <= MAX_RATIO);
`endif
    endfunction

    always @(posedge clk) begin
        bit ok;
        int r;
        cyc++;
        if (rst) begin
            m_armed = 1; m_en = 0; m_busy = 0; m_err = 0; m_ratio = 1; m_has_pend = 0;
        end else if (m_busy) begin
            if (m_has_pend && cyc == m_apply) m_ratio = m_pend;
            if (cyc == m_decide) begin
                m_busy     = 0;
                m_has_pend = 0;
                m_en       = m_settle_end ? run : 1'b0;
            end
        end else begin
            ok = 0;
            if (cfg_valid) begin
                model_decode(int'(cfg_data), ok, r);
                m_err = !ok;
            end
            if (m_en) begin
                if (ok || !run) begin
                    m_en = 0; m_busy = 1;
                    m_has_pend   = ok;
                    m_pend       = r;
                    m_apply      = cyc + 2 * m_ratio + 1;
                    m_settle_end = ok;
                    m_decide     = ok ? cyc + 2 * m_ratio + SETTLE_CYCLES + 1 : cyc + 2 * m_ratio;
                end
            end else if (ok) begin
                m_busy = 1; m_has_pend = 1; m_pend = r; m_settle_end = 1;
                m_apply  = cyc + 1;
                m_decide = cyc + SETTLE_CYCLES + 1;
            end else if (run) begin
                m_busy = 1; m_has_pend = 0; m_settle_end = 1;
                m_decide = cyc + SETTLE_CYCLES;
            end
        end
    end

    always @(negedge clk) begin
        if (m_armed) begin
            checks++;
            if (clk_en !== m_en || busy !== m_busy || cfg_err !== m_err || int'(div_ratio) != m_ratio) begin
                fails++;
                $display("[TB] FAIL model_cmp cyc=%0d actual en/busy/err/ratio=%0b/%0b/%0b/%0d expected=%0b/%0b/%0b/%0d",
                         cyc, clk_en, busy, cfg_err, div_ratio, m_en, m_busy, m_err, m_ratio);
            end
        end
    end

    task automatic applyStimulus(input logic v, input logic [5:0] d, input logic r);
        @(negedge clk);
        cfg_valid = v;
        cfg_data  = d;
        run       = r;
    endtask

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic waitNotBusy(input string tag);
        int n = 0;
        while (busy !== 1'b0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "_busy_drop"}, int'(busy), 0);
    endtask

    task automatic countToEnable(input string tag, input int exp);
        int n = 0;
        while (n < 100) begin
            @(negedge clk);
            cfg_valid = 1'b0;
            n++;
            if (clk_en === 1'b1) break;
        end
        checkOutput(tag, n, exp);
    endtask

    initial begin
        logic [5:0] map_codes [8];
        map_codes = '{6'd4, 6'd8, 6'd16, 6'd32, 6'd0, 6'd12, 6'd5, 6'd63};

        repeat (2) @(negedge clk);
        rst = 1'b0;
        checkOutput("reset_ratio", int'(div_ratio), 1);
        checkOutput("reset_en", int'(clk_en), 0);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_err", int'(cfg_err), 0);

        applyStimulus(1'b0, 6'd0, 1'b1);
        countToEnable("run_to_enable", SETTLE_CYCLES + 1);
        checkOutput("run_ratio", int'(div_ratio), 1);

        applyStimulus(1'b1, CODE_A, 1'b1);
        countToEnable("change_latency", 8);
        checkOutput("change_ratio", int'(div_ratio), RAT_A);
        checkOutput("divided_period_ns", int'(div_ratio) * 10, 40);

        applyStimulus(1'b1, BAD1, 1'b1);
        applyStimulus(1'b0, 6'd0, 1'b1);
        checkOutput("bad1_err", int'(cfg_err), 1);
        checkOutput("bad1_ratio", int'(div_ratio), RAT_A);
        checkOutput("bad1_en", int'(clk_en), 1);
        applyStimulus(1'b1, BAD2, 1'b1);
        applyStimulus(1'b0, 6'd0, 1'b1);
        checkOutput("bad2_err", int'(cfg_err), 1);
        checkOutput("bad2_en", int'(clk_en), 1);
        applyStimulus(1'b1, CODE_B, 1'b1);
        applyStimulus(1'b0, 6'd0, 1'b1);
        checkOutput("err_cleared", int'(cfg_err), 0);
        waitNotBusy("b");
        checkOutput("b_ratio", int'(div_ratio), RAT_B);
        checkOutput("b_en", int'(clk_en), 1);

        applyStimulus(1'b1, CODE_C, 1'b1);
        applyStimulus(1'b1, CODE_D, 1'b1);
        applyStimulus(1'b0, 6'd0, 1'b1);
        checkOutput("drop_busy", int'(busy), 1);
        waitNotBusy("c");
        checkOutput("drop_ratio", int'(div_ratio), RAT_C);
        checkOutput("drop_err", int'(cfg_err), 0);

        applyStimulus(1'b1, CODE_A, 1'b1);
        applyStimulus(1'b0, 6'd0, 1'b1);
        checkOutput("drain_busy", int'(busy), 1);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midrst_en", int'(clk_en), 0);
        checkOutput("midrst_busy", int'(busy), 0);
        checkOutput("midrst_ratio", int'(div_ratio), 1);
        checkOutput("midrst_err", int'(cfg_err), 0);
        rst = 1'b0;
        countToEnable("rerun_enable", SETTLE_CYCLES + 1);

        applyStimulus(1'b1, CODE_B, 1'b0);
        applyStimulus(1'b0, 6'd0, 1'b0);
        waitNotBusy("runfall");
        checkOutput("runfall_en", int'(clk_en), 0);
        checkOutput("runfall_ratio", int'(div_ratio), RAT_B);

        run = 1'b1;
        for (int i = 0; i < 2500; i++) begin
            @(negedge clk);
            rst       = ($urandom_range(0, 399) == 0);
            cfg_valid = ($urandom_range(0, 3) == 0);
`ifdef CLK_DIV_PRESCALE_MAP_EN
            cfg_data  = map_codes[$urandom_range(0, 7)];
`else
            cfg_data  = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 12));
`endif
            if ($urandom_range(0, 29) == 0) run = ~run;
        end
        @(negedge clk);
        rst = 1'b0;
        cfg_valid = 1'b0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
